// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory: load/store wins by
// default, fetch is forced through after MAX_DEFER consecutive deferrals.
module mem_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 1,
  parameter int MAX_DEFER = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  localparam int         TAIL      = MEM_LAT - 1;
  localparam logic [3:0] DEFER_MAX = 4'(MAX_DEFER);
  localparam logic [1:0] WAIT_INIT = 2'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  state_t     state;
  logic [3:0] defer_cnt;
  logic [1:0] wait_cnt;
  logic       can_grant;
  logic       force_if;
  logic       grant_if;
  logic       grant_ls;

  // Per-stage record of an access in flight: valid, owner is fetch, data to capture.
  logic [MEM_LAT-1:0] pipe_v;
  logic [MEM_LAT-1:0] pipe_if;
  logic [MEM_LAT-1:0] pipe_rd;

  // Grants are suppressed while reset is asserted so every output reads zero.
  assign can_grant = (state == IDLE) && !rst;
  assign force_if  = if_req && (defer_cnt == DEFER_MAX);
  assign grant_if  = can_grant && if_req && (force_if || !ls_req);
  assign grant_ls  = can_grant && ls_req && !force_if;

  assign if_gnt    = grant_if;
  assign ls_gnt    = grant_ls;
  assign mem_en    = grant_if | grant_ls;
  assign mem_we    = grant_ls & ls_we;
  assign mem_addr  = grant_ls ? ls_addr : (grant_if ? if_addr : '0);
  assign mem_wdata = grant_ls ? ls_wdata : '0;
  assign busy      = (state == WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      defer_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ls && if_req) begin
            if (defer_cnt != DEFER_MAX)
              defer_cnt <= defer_cnt + 4'd1;
          end else begin
            defer_cnt <= '0;
          end
          if (mem_en && (MEM_LAT > 1)) begin
            state    <= WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0)
            state <= IDLE;
          else
            wait_cnt <= wait_cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The tail stage lines up with the cycle in which the memory drives read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v    <= '0;
      pipe_if   <= '0;
      pipe_rd   <= '0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      pipe_v[0]  <= mem_en;
      pipe_if[0] <= grant_if;
      pipe_rd[0] <= grant_if | (grant_ls & ~ls_we);
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_if[i] <= pipe_if[i-1];
        pipe_rd[i] <= pipe_rd[i-1];
      end
      if_rvalid <= pipe_v[TAIL] & pipe_if[TAIL];
      ls_rvalid <= pipe_v[TAIL] & ~pipe_if[TAIL];
      if (pipe_v[TAIL] && pipe_rd[TAIL]) begin
        if (pipe_if[TAIL])
          if_rdata <= mem_rdata;
        else
          ls_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance 0 runs MEM_LAT=1, instance 1 MEM_LAT=3,
// each behind its own memory model that drives read data only in the cycle it is valid.
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;

  typedef struct {
    bit            is_if;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req    [2];
  logic [AW-1:0] if_addr   [2];
  logic          if_gnt    [2];
  logic          if_rvalid [2];
  logic [DW-1:0] if_rdata  [2];
  logic          ls_req    [2];
  logic          ls_we     [2];
  logic [AW-1:0] ls_addr   [2];
  logic [DW-1:0] ls_wdata  [2];
  logic          ls_gnt    [2];
  logic          ls_rvalid [2];
  logic [DW-1:0] ls_rdata  [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy      [2];

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic [DW-1:0] mem [2][1024];
  bit            wr  [2][1024];
  bit            rv  [2][4];
  logic [DW-1:0] rd  [2][4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_DEFER(4)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .ls_req(ls_req[0]), .ls_we(ls_we[0]), .ls_addr(ls_addr[0]), .ls_wdata(ls_wdata[0]),
    .ls_gnt(ls_gnt[0]), .ls_rvalid(ls_rvalid[0]), .ls_rdata(ls_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .MAX_DEFER(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .ls_req(ls_req[1]), .ls_we(ls_we[1]), .ls_addr(ls_addr[1]), .ls_wdata(ls_wdata[1]),
    .ls_gnt(ls_gnt[1]), .ls_rvalid(ls_rvalid[1]), .ls_rdata(ls_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Unwritten locations read a recognisable address-derived pattern.
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return (a == 10'h010) ? 16'hA5A5 : (16'hC000 | {6'd0, a});
  endfunction

  // Memory model; 16'h0BAD appears on mem_rdata whenever no read data is due.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k] && mem_we[k]) begin
        mem[k][mem_addr[k]] <= mem_wdata[k];
        wr[k][mem_addr[k]]  <= 1'b1;
      end
      rv[k][0] <= mem_en[k] && !mem_we[k];
      rd[k][0] <= wr[k][mem_addr[k]] ? mem[k][mem_addr[k]] : dflt(mem_addr[k]);
      for (int i = 1; i < 4; i++) begin
        rv[k][i] <= rv[k][i-1];
        rd[k][i] <= rd[k][i-1];
      end
    end
  end
  assign mem_rdata[0] = rv[0][0] ? rd[0][0] : 16'h0BAD;
  assign mem_rdata[1] = rv[1][2] ? rd[1][2] : 16'h0BAD;

  task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                             input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d cycle %0d: actual=%h required=%h", name, k, cyc, act, req);
    end
  endtask

  task automatic push(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: every response pulse pops the oldest expectation for that instance.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (if_rvalid[k] || ls_rvalid[k]) begin
        exp_t e;
        bit   have;
        have = 1'b0;
        if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
          checkOutput("rsp_unexpected", k, 32'd1, 32'd0);
        end else begin
          checkOutput("rsp_if_rvalid", k, 32'(if_rvalid[k]), 32'(e.is_if));
          checkOutput("rsp_ls_rvalid", k, 32'(ls_rvalid[k]), 32'(!e.is_if));
          checkOutput("rsp_cycle", k, 32'(cyc), 32'(e.cyc));
          checkOutput("rsp_data", k, 32'(e.is_if ? if_rdata[k] : ls_rdata[k]), 32'(e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Issue one request, hold it until granted, check the grant-cycle memory strobe.
  task automatic applyStimulus(input int k, input bit is_if, input bit we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [DW-1:0] exp_data);
    bit got;
    got = 1'b0;
    if (is_if) begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end else begin
      ls_req[k] = 1'b1; ls_we[k] = we; ls_addr[k] = addr; ls_wdata[k] = wdata;
    end
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (is_if ? if_gnt[k] : ls_gnt[k]) begin
        exp_t e;
        got = 1'b1;
        checkOutput("gnt_other", k, 32'(is_if ? ls_gnt[k] : if_gnt[k]), 32'd0);
        checkOutput("gnt_mem_en", k, 32'(mem_en[k]), 32'd1);
        checkOutput("gnt_mem_addr", k, 32'(mem_addr[k]), 32'(addr));
        checkOutput("gnt_mem_we", k, 32'(mem_we[k]), 32'(we));
        checkOutput("gnt_mem_wdata", k, 32'(mem_wdata[k]), 32'(is_if ? 16'h0 : wdata));
        e.is_if = is_if;
        e.data  = exp_data;
        e.cyc   = cyc + lat_of(k) + 1;
        push(k, e);
      end
      tick();
    end
    if_req[k] = 1'b0;
    ls_req[k] = 1'b0;
    if (!got) checkOutput("gnt_timeout", k, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    // Reset with random requests: every output must stay low.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 2; k++) begin
        if_req[k]   = 1'($urandom);
        if_addr[k]  = AW'($urandom);
        ls_req[k]   = 1'($urandom);
        ls_we[k]    = 1'($urandom);
        ls_addr[k]  = AW'($urandom);
        ls_wdata[k] = DW'($urandom);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        checkOutput("rst_outputs", k,
                    32'({if_gnt[k], ls_gnt[k], if_rvalid[k], ls_rvalid[k], mem_en[k],
                         mem_we[k], busy[k], mem_addr[k], mem_wdata[k], if_rdata[k],
                         ls_rdata[k]}), 32'd0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; ls_req[k] = 1'b0; ls_we[k] = 1'b0;
      if_addr[k] = '0; ls_addr[k] = '0; ls_wdata[k] = '0;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idle_mem_en", 0, 32'(mem_en[0]), 32'd0);
      checkOutput("idle_mem_en", 1, 32'(mem_en[1]), 32'd0);
      tick();
    end

    // Single fetch, MEM_LAT=1.
    applyStimulus(0, 1'b1, 1'b0, 10'h010, 16'h0000, 16'hA5A5);
    idle(4);
    @(negedge clk);
    checkOutput("if_rdata_hold", 0, 32'(if_rdata[0]), 32'h0000A5A5);
    tick();

    // Store then back-to-back load of the same word.
    applyStimulus(0, 1'b0, 1'b1, 10'h005, 16'h1234, 16'h0000);
    applyStimulus(0, 1'b0, 1'b0, 10'h005, 16'h0000, 16'h1234);
    idle(4);

    // Contention: LS x4 then a forced IF, repeating.
    if_req[0] = 1'b1; if_addr[0] = 10'h010;
    ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_addr[0] = 10'h005;
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      bit   exp_if;
      exp_if = (i == 4) || (i == 9);
      @(negedge clk);
      checkOutput("contend_if_gnt", 0, 32'(if_gnt[0]), 32'(exp_if));
      checkOutput("contend_ls_gnt", 0, 32'(ls_gnt[0]), 32'(!exp_if));
      e.is_if = exp_if;
      e.data  = exp_if ? 16'hA5A5 : 16'h1234;
      e.cyc   = cyc + 2;
      push(0, e);
      tick();
    end
    if_req[0] = 1'b0;
    ls_req[0] = 1'b0;
    idle(4);

    // MEM_LAT=3: continuous loads, one grant every third cycle.
    begin
      int n;
      n = 0;
      ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 10'h020;
      for (int t = 0; t < 12; t++) begin
        bit exp_g;
        exp_g = (t % 3 == 0);
        @(negedge clk);
        checkOutput("lat3_ls_gnt", 1, 32'(ls_gnt[1]), 32'(exp_g));
        checkOutput("lat3_busy", 1, 32'(busy[1]), 32'(!exp_g));
        if (exp_g) begin
          exp_t e;
          e.is_if = 1'b0;
          e.data  = 16'hC020 + 16'(n);
          e.cyc   = cyc + 4;
          push(1, e);
        end
        tick();
        if (exp_g) begin
          n++;
          ls_addr[1] = 10'h020 + 10'(n);
        end
      end
      ls_req[1] = 1'b0;
    end
    idle(4);

    // Fetch on the MEM_LAT=3 instance so if_rdata is non-zero before the reset test.
    applyStimulus(1, 1'b1, 1'b0, 10'h040, 16'h0000, 16'hC040);
    idle(6);

    // Reset in the cycle after a grant cancels the pending response.
    if_req[1] = 1'b1; if_addr[1] = 10'h030;
    @(negedge clk);
    checkOutput("midrst_gnt", 1, 32'(if_gnt[1]), 32'd1);
    tick();
    if_req[1] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", 1, 32'(busy[1]), 32'd0);
    checkOutput("midrst_if_rdata", 1, 32'(if_rdata[1]), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_no_rvalid", 1, 32'(if_rvalid[1]), 32'd0);
    tick();
    applyStimulus(1, 1'b1, 1'b0, 10'h030, 16'h0000, 16'hC030);
    idle(8);

    checkOutput("sb_leftover", 0, 32'(q0.size()), 32'd0);
    checkOutput("sb_leftover", 1, 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-port synchronous memory between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the processor's fetch/execute stages and the memory.
- Grants one access at a time. LS has priority, with a bounded-deferral rule so fetch cannot starve.
- Returns read data and completion pulses to the owning requester, with the memory's read latency handled internally.

Parameters:
- ADDR_W, 10, memory word-address width.
- DATA_W, 16, data word width.
- MEM_LAT, 1, memory read latency in cycles (legal 1..4).
- MAX_DEFER, 4, consecutive fetch deferrals before fetch is forced priority (legal 1..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  registered fetch data; held until next fetch response.
- ls_req  in  1  load/store request; held with ls_we/ls_addr/ls_wdata stable until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_gnt  out  1  load/store accepted this cycle (combinational).
- ls_rvalid  out  1  one-cycle completion pulse (loads and stores).
- ls_rdata  out  DATA_W  registered load data; held until next load response.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.
- busy  out  1  arbiter in WAIT; no grant possible.

Behaviour:
- Reset: state=IDLE, defer_cnt=0, all pending responses cancelled.
  - All outputs 0, including if_rdata and ls_rdata.
  - An in-flight access at reset produces no rvalid.
- States:
  - IDLE: may grant.
  - WAIT: counting latency, no grant.
- Grant decision, made only in IDLE, in grant cycle G:
  - If if_req && defer_cnt==MAX_DEFER: grant IF.
  - Else if ls_req: grant LS.
  - Else if if_req: grant IF.
  - Else: no grant.
- Grant cycle outputs:
  - Exactly one of if_gnt/ls_gnt is high.
  - mem_en=1; mem_addr and mem_wdata come from the winner.
  - mem_we=ls_we for an LS grant, 0 for an IF grant.
- Outside a grant cycle, mem_en, mem_we, mem_addr and mem_wdata are all 0.
- defer_cnt updates at each IDLE decision:
  - LS granted while if_req=1: increment, saturating at MAX_DEFER.
  - IF granted, or if_req=0: clear to 0.
  - Holds during WAIT.
- State after a grant:
  - MEM_LAT==1: stay IDLE; back-to-back grants allowed every cycle.
  - MEM_LAT>1: enter WAIT for MEM_LAT-1 cycles, then IDLE. The next grant is at earliest cycle G+MEM_LAT.
- busy=1 exactly during WAIT cycles.
- Response:
  - Owner and type are recorded at grant.
  - At the end of cycle G+MEM_LAT, mem_rdata is captured into the owner's rdata register (loads/fetches only).
  - The owner's rvalid is high in cycle G+MEM_LAT+1 for one cycle.
  - Stores pulse ls_rvalid at the same timing; ls_rdata is unchanged.
- Overlap: for MEM_LAT==1, a response pulse for access N and a grant for access N+1 may coincide. Both are handled independently.
- Request withdrawn before grant: no access and no error; the requester must not do this (bench checks nothing is issued).

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, busy=0; after release with no req, mem_en stays 0.
- Single fetch, MEM_LAT=1:
  - Stimulus: if_req=1, if_addr=0x010 in cycle 5; memory returns 0xA5A5.
  - Required: if_gnt=1, mem_en=1, mem_addr=0x010, mem_we=0 in cycle 5.
  - Required: if_rvalid=1 in cycle 7 with if_rdata=0xA5A5, which holds afterwards.
- Store then load, MEM_LAT=1:
  - Stimulus: LS store 0x1234 to 0x005, then load from 0x005.
  - Required: mem_we=1 on the first grant; ls_rvalid pulses at G+2 with ls_rdata unchanged.
  - Required: the load returns 0x1234 with ls_rvalid at G+3.
- Contention/starvation, MAX_DEFER=4:
  - Stimulus: if_req and ls_req held continuously.
  - Required: grants LS,LS,LS,LS,IF,LS,LS,LS,LS,IF...
  - Required: defer_cnt reads 0,1,2,3,4,0.
- MEM_LAT=3:
  - Stimulus: continuous ls_req loads.
  - Required: grants every 3 cycles; busy high 2 cycles after each grant.
  - Required: ls_rvalid at G+4 with mem_rdata sampled at G+3.
- Reset mid-operation:
  - Stimulus: MEM_LAT=3, IF grant at cycle G, rst=1 in G+1.
  - Required: no if_rvalid at G+4; state IDLE and if_rdata=0 after reset.
